// File: rtl/xf100_ram_initiator.sv
// xf100_ram_initiator
// Master-side controller for the xf100 word-organised RAM port. It accepts
// byte-addressed load/store requests on a valid/ready channel, checks size,
// alignment and window range, issues exactly one RAM access per legal
// request and returns an extended load result or an error on a valid/ready
// response channel. The response is held stable under backpressure.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_wen, req_addr,         store flag, byte address,
//   req_size, req_unsigned,    size (0 byte, 1 half, 2 word),
//   req_wdata                  zero-extension flag, right-aligned store data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         load result (0 for stores/errors), error flag
//   ram_cs, ram_wen, ram_mask  RAM select, write enable, byte enables
//   ram_addr                   RAM word address
//   ram_wdat0..3, ram_rdat0..3 write/read byte lanes (lane k = byte offset k)
module xf100_ram_initiator #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DP        = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wen,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_cs,
  output logic          ram_wen,
  output logic [3:0]    ram_mask,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdat0,
  output logic [7:0]    ram_wdat1,
  output logic [7:0]    ram_wdat2,
  output logic [7:0]    ram_wdat3,
  input  logic [7:0]    ram_rdat0,
  input  logic [7:0]    ram_rdat1,
  input  logic [7:0]    ram_rdat2,
  input  logic [7:0]    ram_rdat3
);

  typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

  localparam logic [AW:0] DP_LIMIT = (AW+1)'(DP);

  state_t        state;
  logic [1:0]    acc_off;
  logic [1:0]    acc_size;
  logic          acc_uns;

  logic [AW-1:0] req_word;
  logic          req_err;
  logic [3:0]    req_mask;
  logic [31:0]   req_lanes;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;

  assign req_word = req_addr[AW+1:2];
  assign rd_word  = {ram_rdat3, ram_rdat2, ram_rdat1, ram_rdat0};
  assign rd_byte  = rd_word[{acc_off, 3'b000} +: 8];
  assign rd_half  = acc_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3)
      req_err = 1'b1;
    if (req_size == 2'd1 && req_addr[0] != 1'b0)
      req_err = 1'b1;
    if (req_size == 2'd2 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if (req_addr[31:AW+2] != BASE_ADDR[31:AW+2])
      req_err = 1'b1;
    if ({1'b0, req_word} >= DP_LIMIT)
      req_err = 1'b1;
  end

  // Store data is replicated so the selected lanes carry the right bytes
  // whatever the offset; the mask picks which lanes the RAM actually takes.
  always_comb begin
    req_mask  = 4'b1111;
    req_lanes = req_wdata;
    case (req_size)
      2'd0: begin
        req_mask  = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        req_mask  = 4'b1111;
        req_lanes = req_wdata;
      end
    endcase
  end

  always_comb begin
    load_data = rd_word;
    case (acc_size)
      2'd0:    load_data = acc_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'd1:    load_data = acc_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ram_cs    <= 1'b0;
      ram_wen   <= 1'b0;
      ram_mask  <= '0;
      ram_addr  <= '0;
      ram_wdat0 <= '0;
      ram_wdat1 <= '0;
      ram_wdat2 <= '0;
      ram_wdat3 <= '0;
      acc_off   <= '0;
      acc_size  <= '0;
      acc_uns   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            acc_off   <= req_addr[1:0];
            acc_size  <= req_size;
            acc_uns   <= req_unsigned;
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RSP;
            end else begin
              // RAM port outputs are registered here so ACC drives them
              // straight from flops for its single cycle.
              ram_cs    <= 1'b1;
              ram_wen   <= req_wen;
              ram_mask  <= req_mask;
              ram_addr  <= req_word;
              ram_wdat0 <= req_lanes[7:0];
              ram_wdat1 <= req_lanes[15:8];
              ram_wdat2 <= req_lanes[23:16];
              ram_wdat3 <= req_lanes[31:24];
              state     <= ACC;
            end
          end
        end
        ACC: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ram_wen ? '0 : load_data;
          ram_cs    <= 1'b0;
          ram_wen   <= 1'b0;
          ram_mask  <= '0;
          ram_addr  <= '0;
          ram_wdat0 <= '0;
          ram_wdat1 <= '0;
          ram_wdat2 <= '0;
          ram_wdat3 <= '0;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xf100_ram_initiator.sv
// Testbench for xf100_ram_initiator: a byte-array RAM attached to the port,
// a byte-level reference memory, and directed plus randomized requests.
module tb_xf100_ram_initiator;

  localparam int unsigned AW   = 8;
  localparam int unsigned DP   = 256;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_size;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          ram_cs, ram_wen;
  logic [3:0]    ram_mask;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdat0, ram_wdat1, ram_wdat2, ram_wdat3;
  logic [7:0]    ram_rdat0, ram_rdat1, ram_rdat2, ram_rdat3;

  int n_checks = 0;
  int n_fail   = 0;

  xf100_ram_initiator #(.AW(AW), .DP(DP), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_cs(ram_cs), .ram_wen(ram_wen), .ram_mask(ram_mask), .ram_addr(ram_addr),
    .ram_wdat0(ram_wdat0), .ram_wdat1(ram_wdat1), .ram_wdat2(ram_wdat2),
    .ram_wdat3(ram_wdat3),
    .ram_rdat0(ram_rdat0), .ram_rdat1(ram_rdat1), .ram_rdat2(ram_rdat2),
    .ram_rdat3(ram_rdat3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM attached to the port
  logic [7:0] ram_mem [DP][4];
  logic [7:0] wl [4];
  assign wl[0] = ram_wdat0;
  assign wl[1] = ram_wdat1;
  assign wl[2] = ram_wdat2;
  assign wl[3] = ram_wdat3;

  always @(posedge clk) begin
    if (ram_cs && ram_wen)
      for (int k = 0; k < 4; k++)
        if (ram_mask[k]) ram_mem[ram_addr][k] <= wl[k];
  end

  assign ram_rdat0 = (ram_cs && !ram_wen) ? ram_mem[ram_addr][0] : 8'hEE;
  assign ram_rdat1 = (ram_cs && !ram_wen) ? ram_mem[ram_addr][1] : 8'hEE;
  assign ram_rdat2 = (ram_cs && !ram_wen) ? ram_mem[ram_addr][2] : 8'hEE;
  assign ram_rdat3 = (ram_cs && !ram_wen) ? ram_mem[ram_addr][3] : 8'hEE;

  // Reference model: flat byte-addressed memory of the window
  logic [7:0] ref_mem [DP*4];

  function automatic bit f_err(logic [31:0] a, logic [1:0] s);
    longint off = longint'(a) - longint'(BASE);
    if (s == 2'd3) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    if (off < 0 || off >= longint'(DP) * 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] f_load(logic [31:0] a, logic [1:0] s, logic u);
    int unsigned off = a - BASE;
    int unsigned n = 1 << s;
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = ref_mem[off + i];
    if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
    return v;
  endfunction

  task automatic ref_store(logic [31:0] a, logic [1:0] s, logic [31:0] wd);
    int unsigned off = a - BASE;
    for (int unsigned i = 0; i < (1 << s); i++) ref_mem[off + i] = wd[8*i +: 8];
  endtask

  function automatic logic [3:0] f_mask(logic [31:0] a, logic [1:0] s);
    logic [3:0] m = '0;
    for (int unsigned i = 0; i < (1 << s); i++) m[(a % 4) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] f_lanes(logic [1:0] s, logic [31:0] wd);
    logic [31:0] l;
    int unsigned n = 1 << s;
    for (int unsigned k = 0; k < 4; k++) l[8*k +: 8] = wd[8*(k % n) +: 8];
    return l;
  endfunction

  // Observations of the most recent transaction
  int          o_lat, o_cs, o_cs_cyc;
  logic        o_wen, o_err;
  logic [3:0]  o_mask;
  logic [AW-1:0] o_addr;
  logic [31:0] o_lanes, o_rdata;

  task automatic send(logic w, logic [31:0] a, logic [1:0] s, logic u, logic [31:0] wd);
    bit ok = 1'b0;
    req_wen = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL req_accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_rsp();
    o_lat = 99; o_cs = 0; o_cs_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ram_cs === 1'b1) begin
        o_cs++; o_cs_cyc = c;
        o_wen = ram_wen; o_mask = ram_mask; o_addr = ram_addr;
        o_lanes = {ram_wdat3, ram_wdat2, ram_wdat1, ram_wdat0};
      end
      if (rsp_valid === 1'b1) begin
        o_lat = c; o_rdata = rsp_rdata; o_err = rsp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume(int d);
    repeat (d) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
        n_fail++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h want 0", rsp_valid, rsp_err, rsp_rdata);
      end
      n_checks++;
      if ({ram_cs, ram_wen, ram_mask, ram_addr, ram_wdat3, ram_wdat2, ram_wdat1, ram_wdat0} !== '0) begin
        n_fail++; $display("FAIL reset_ram: cs=%b wen=%b mask=%b addr=%h want all 0", ram_cs, ram_wen, ram_mask, ram_addr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_word();
    send(1'b1, 32'h10, 2'd2, 1'b0, 32'hA1B2C3D4);
    wait_rsp();
    ref_store(32'h10, 2'd2, 32'hA1B2C3D4);
    n_checks++;
    if (o_cs !== 1 || o_cs_cyc !== 1 || o_lat !== 2) begin
      n_fail++; $display("FAIL sw_timing: cs=%0d cs_cyc=%0d lat=%0d want 1 1 2", o_cs, o_cs_cyc, o_lat);
    end
    n_checks++;
    if ({o_wen, o_mask, o_addr} !== {1'b1, 4'b1111, 8'd4}) begin
      n_fail++; $display("FAIL sw_ctrl: wen=%b mask=%b addr=%h want 1 1111 04", o_wen, o_mask, o_addr);
    end
    n_checks++;
    if (o_lanes !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL sw_lanes: got %h want a1b2c3d4", o_lanes); end
    n_checks++;
    if ({o_err, o_rdata} !== 33'h0) begin n_fail++; $display("FAIL sw_rsp: err=%b rdata=%h want 0 0", o_err, o_rdata); end
    consume(0);
    send(1'b0, 32'h10, 2'd2, 1'b0, $urandom);
    wait_rsp();
    n_checks++;
    if ({o_err, o_rdata} !== {1'b0, 32'hA1B2C3D4}) begin
      n_fail++; $display("FAIL lw_rsp: err=%b rdata=%h want 0 a1b2c3d4", o_err, o_rdata);
    end
    n_checks++;
    if ({o_wen, o_mask} !== {1'b0, 4'b1111}) begin n_fail++; $display("FAIL lw_ctrl: wen=%b mask=%b want 0 1111", o_wen, o_mask); end
    consume(0);
  endtask

  task automatic test_extend();
    logic [31:0] t_addr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [1:0]  t_size [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        t_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_exp  [4] = '{32'hFFFFFFA1, 32'h000000A1, 32'hFFFFA1B2, 32'h0000C3D4};
    logic [3:0]  t_msk  [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      send(1'b0, t_addr[i], t_size[i], t_uns[i], $urandom);
      wait_rsp();
      n_checks++;
      if ({o_err, o_rdata} !== {1'b0, t_exp[i]}) begin
        n_fail++; $display("FAIL ext_load%0d: err=%b rdata=%h want 0 %h", i, o_err, o_rdata, t_exp[i]);
      end
      n_checks++;
      if (o_mask !== t_msk[i]) begin n_fail++; $display("FAIL ext_mask%0d: got %b want %b", i, o_mask, t_msk[i]); end
      consume(0);
    end
  endtask

  task automatic test_subword();
    send(1'b1, 32'h11, 2'd0, 1'b0, 32'h9876_5455);
    wait_rsp();
    ref_store(32'h11, 2'd0, 32'h9876_5455);
    n_checks++;
    if ({o_mask, o_lanes} !== {4'b0010, 32'h55555555}) begin
      n_fail++; $display("FAIL sb_port: mask=%b lanes=%h want 0010 55555555", o_mask, o_lanes);
    end
    consume(1);
    send(1'b0, 32'h10, 2'd2, 1'b1, $urandom);
    wait_rsp();
    n_checks++;
    if (o_rdata !== 32'hA1B255D4) begin n_fail++; $display("FAIL sb_readback: got %h want a1b255d4", o_rdata); end
    consume(0);
  endtask

  task automatic test_errors();
    logic [31:0] e_addr [4] = '{32'h12, 32'h11, 32'h10, DP*4};
    logic [1:0]  e_size [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic        e_wen  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(e_wen[i], e_addr[i], e_size[i], 1'b0, $urandom);
      wait_rsp();
      n_checks++;
      if ({o_err, o_rdata} !== {1'b1, 32'h0}) begin
        n_fail++; $display("FAIL err_rsp%0d: err=%b rdata=%h want 1 0", i, o_err, o_rdata);
      end
      n_checks++;
      if (o_cs !== 0 || o_lat !== 1) begin
        n_fail++; $display("FAIL err_timing%0d: cs=%0d lat=%0d want 0 1", i, o_cs, o_lat);
      end
      consume(0);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL idle_rsp_ready: req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
      end
    end
    rsp_ready = 1'b0;
    send(1'b0, 32'h10, 2'd2, 1'b0, $urandom);
    wait_rsp();
    // a store offered while busy must be ignored
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hA1B255D4}) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b err=%b rdata=%h want 1 0 a1b255d4", i, rsp_valid, rsp_err, rsp_rdata);
      end
      n_checks++;
      if (req_ready !== 1'b0 || ram_cs !== 1'b0) begin
        n_fail++; $display("FAIL bp_quiet%0d: req_ready=%b ram_cs=%b want 0 0", i, req_ready, ram_cs);
      end
    end
    req_valid = 1'b0;
    consume(0);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
    send(1'b0, 32'h10, 2'd2, 1'b0, $urandom);
    wait_rsp();
    n_checks++;
    if (o_rdata !== 32'hA1B255D4) begin n_fail++; $display("FAIL bp_ignored_store: got %h want a1b255d4", o_rdata); end
    consume(0);
  endtask

  task automatic test_reset_mid();
    for (int ph = 0; ph < 2; ph++) begin
      send(1'b0, 32'h20, 2'd2, 1'b0, $urandom);
      if (ph == 1) wait_rsp();
      rsp_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || ram_cs !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL rst_mid%0d: rsp_valid=%b ram_cs=%b req_ready=%b want 0 0 1", ph, rsp_valid, ram_cs, req_ready);
      end
      repeat (3) begin
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale%0d: rsp_valid=%b want 0", ph, rsp_valid); end
      end
      rsp_ready = 1'b0;
    end
    send(1'b0, 32'h20, 2'd2, 1'b0, $urandom);
    wait_rsp();
    n_checks++;
    if (o_rdata !== f_load(32'h20, 2'd2, 1'b0)) begin
      n_fail++; $display("FAIL rst_recover: got %h want %h", o_rdata, f_load(32'h20, 2'd2, 1'b0));
    end
    consume(0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      logic        w = 1'($urandom_range(0, 1));
      logic        u = 1'($urandom_range(0, 1));
      logic [1:0]  s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      logic [31:0] wd = $urandom;
      logic [31:0] a;
      int          r = $urandom_range(0, 19);
      bit          e;
      logic [31:0] exp_rd;
      if (r == 0)      a = BASE + DP*4 + $urandom_range(0, 4095);
      else if (r == 1) a = $urandom;
      else             a = BASE + $urandom_range(0, DP*4 - 1);
      if (s != 2'd3 && $urandom_range(0, 9) < 7) a = a & ~((32'd1 << s) - 1);
      e = f_err(a, s);
      exp_rd = (e || w) ? 32'h0 : f_load(a, s, u);
      send(w, a, s, u, wd);
      wait_rsp();
      n_checks++;
      if ({o_err, o_rdata} !== {e, exp_rd}) begin
        n_fail++; $display("FAIL rnd_rsp%0d: a=%h s=%0d w=%b err=%b rdata=%h want %b %h", it, a, s, w, o_err, o_rdata, e, exp_rd);
      end
      n_checks++;
      if (o_lat !== (e ? 1 : 2) || o_cs !== (e ? 0 : 1)) begin
        n_fail++; $display("FAIL rnd_timing%0d: lat=%0d cs=%0d want %0d %0d", it, o_lat, o_cs, e ? 1 : 2, e ? 0 : 1);
      end
      if (!e) begin
        n_checks++;
        if ({o_wen, o_mask, o_addr} !== {w, f_mask(a, s), AW'((a - BASE) >> 2)}) begin
          n_fail++; $display("FAIL rnd_ctrl%0d: wen=%b mask=%b addr=%h want %b %b %h", it, o_wen, o_mask, o_addr, w, f_mask(a, s), AW'((a - BASE) >> 2));
        end
        if (w) begin
          n_checks++;
          if (o_lanes !== f_lanes(s, wd)) begin
            n_fail++; $display("FAIL rnd_lanes%0d: got %h want %h", it, o_lanes, f_lanes(s, wd));
          end
          ref_store(a, s, wd);
        end
      end
      consume($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < DP; i++)
      for (int k = 0; k < 4; k++) begin
        ram_mem[i][k] = 8'($urandom);
        ref_mem[i*4 + k] = ram_mem[i][k];
      end
    @(negedge clk);
    test_reset();
    test_word();
    test_extend();
    test_subword();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
